stopwatch_uart_reporter: RTL and testbench
==========================================

# stopwatch_uart_reporter

Transmit-side companion to the stopwatch UART command path. On a request, it snapshots the stopwatch time (hour/min/sec/centisecond) and sends it to the UART transmitter as a 13-byte ASCII frame, `HH:MM:SS.CC\r\n`. It sits between the stopwatch datapath outputs and the UART TX engine, and uses a start/done byte handshake.

## Interface

Parameters:
- REPORT_PERIOD, 100_000_000, period in clk cycles between automatic reports. Used only when REPORTER_PERIODIC_EN is defined. Must be ≥ 2.

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-high reset
- i_report  input  1  report request; level sampled each cycle, a single-cycle pulse is sufficient
- i_msec  input  7  centiseconds, 0..99 nominal
- i_sec  input  6  seconds, 0..59
- i_min  input  6  minutes, 0..59
- i_hour  input  5  hours, 0..23
- i_tx_done  input  1  one-cycle pulse from UART TX when the current byte has finished
- o_tx_start  output  1  one-cycle pulse requesting transmission of o_tx_data
- o_tx_data  output  8  byte to send
- o_busy  output  1  frame in progress

## Operation

- States:
  - IDLE
  - SEND: o_tx_start=1 for exactly one cycle
  - WAIT: awaiting i_tx_done
- Trigger: i_report=1 sampled in IDLE (or a periodic tick, see Configuration).
  - On that edge, latch all four time inputs into a snapshot, clear the byte index to 0, and go to SEND.
- SEND → WAIT unconditionally after one cycle.
- WAIT behaviour:
  - i_tx_done=1 with index<12: index+1 and go to SEND.
  - i_tx_done=1 with index=12: frame complete; go to IDLE, or restart if a request is pending.
  - i_tx_done is ignored in IDLE and SEND.
- Byte order, index 0..12:
  - H tens, H ones, ':', M tens, M ones, ':', S tens, S ones, '.', C tens, C ones, 0x0D, 0x0A.
- Digit conversion:
  - Each digit = 0x30 + decimal digit, computed from the snapshot, never from live inputs.
  - Any field value ≥ 100 (only i_msec can reach this) is displayed as "99".
  - Hour 24..31 prints as-is, e.g. 31 → "31".
- Pending request: a trigger arriving while o_busy=1 sets a single pending flag. Multiple triggers collapse into one.
  - At frame completion with pending=1: take a fresh snapshot, set index 0, go directly to SEND, and clear pending. o_busy stays high.
- o_tx_data is registered and stable from the SEND cycle until i_tx_done is sampled.

## Timing

- Reset values: state IDLE, o_tx_start=0, o_tx_data=0x00, o_busy=0, index 0, pending 0, snapshot 0, period counter 0.
- Reset mid-frame: immediate abort. No further bytes are sent and the pending request is discarded.
- Trigger latency: i_report sampled high at edge k gives o_tx_start=1 and o_busy=1 in the cycle after edge k, with o_tx_data=H tens.
- Inter-byte latency: i_tx_done sampled at edge m gives the next o_tx_start in the cycle after edge m (one cycle of dead time).
- o_busy timing:
  - Falls in the cycle after i_tx_done is sampled for byte 12.
  - Minimum frame duration is 13×2 cycles plus UART time.
- A trigger coincident with the final i_tx_done edge counts as pending, so the next frame follows without an IDLE cycle.

## Configuration

- REPORTER_PERIODIC_EN defined:
  - A free-running counter generates a tick every REPORT_PERIOD cycles; it counts 0..REPORT_PERIOD-1 and ticks at wrap.
  - The tick is ORed with i_report, and follows the same IDLE/pending rules.
  - The counter runs regardless of state and is cleared only by reset.
- Not defined: no counter logic. Frames are sent only on i_report, and REPORT_PERIOD is unused.

## Test plan

- Single report. Time 12:34:56.78, i_report pulse, TX model returns done 10 cycles after each start. Required: 13 starts with bytes 31 32 3A 33 34 3A 35 36 2E 37 38 0D 0A, and o_busy high throughout then low.
- Snapshot isolation. Change inputs to 01:02:03.04 after the first byte. Required: the frame still reads "12:34:56.78".
- Pending collapse. Send 3 i_report pulses mid-frame. Required: exactly one extra frame, back-to-back, carrying the time at the completion edge.
- Saturation and zero. Time 00:00:00 with i_msec=120. Required: "00:00:00.99\r\n". Hour 31 prints "31".
- Reset mid-frame. Assert rst during byte 5 with a request pending. Required: outputs return to their reset values immediately, and no starts occur until the next i_report.
- REPORTER_PERIODIC_EN with REPORT_PERIOD=2000 and fast TX. Required: frame starts 2000 cycles apart, and no frames without the macro defined.

Source files
------------

// File: rtl/stopwatch_uart_reporter.sv
// Stopwatch time reporter: snapshots HH:MM:SS.CC and streams it as a 13-byte
// ASCII frame ("HH:MM:SS.CC\r\n") to a UART TX engine with a start/done handshake.
// Optional feature macro: REPORTER_PERIODIC_EN adds a free-running report tick
// every REPORT_PERIOD cycles, ORed with i_report.
module stopwatch_uart_reporter #(
   parameter int unsigned REPORT_PERIOD = 100_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_report,
   input  logic [6:0] i_msec,
   input  logic [5:0] i_sec,
   input  logic [5:0] i_min,
   input  logic [4:0] i_hour,
   input  logic       i_tx_done,
   output logic       o_tx_start,
   output logic [7:0] o_tx_data,
   output logic       o_busy
);

   typedef enum logic [1:0] {StIdle, StSend, StWait} state_e;

   localparam logic [3:0] LastIdx = 4'd12;

   state_e     state_q, state_d;
   logic [3:0] idx_q, idx_d;
   logic       pend_q, pend_d;
   logic [6:0] msec_q, msec_d;
   logic [5:0] sec_q, sec_d;
   logic [5:0] min_q, min_d;
   logic [4:0] hour_q, hour_d;
   logic [7:0] data_q, data_d;
   logic       trig;
   logic       load;

`ifdef REPORTER_PERIODIC_EN
   localparam int unsigned CntW = (REPORT_PERIOD > 1) ? $clog2(REPORT_PERIOD) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REPORT_PERIOD - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            tick;

   assign tick = (cnt_q == CntMax);

   // Free-running period counter, independent of the frame state.
   always_comb begin
      cnt_d = tick ? '0 : cnt_q + CntW'(1);
   end

   // Period counter register; only reset clears it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign trig = i_report | tick;
`else
   assign trig = i_report;
`endif

   // Two ASCII digits of a field; anything >= 100 saturates to "99".
   function automatic logic [15:0] two_digits(input logic [6:0] v);
      logic [6:0] s;
      logic [3:0] t;
      logic [3:0] o;
      s = (v >= 7'd100) ? 7'd99 : v;
      t = 4'(s / 7'd10);
      o = 4'(s % 7'd10);
      return {4'h3, t, 4'h3, o};
   endfunction

   // Frame byte at a given index, built purely from the snapshot values.
   function automatic logic [7:0] frame_byte(input logic [4:0] h, input logic [5:0] m,
                                             input logic [5:0] s, input logic [6:0] c,
                                             input logic [3:0] idx);
      logic [15:0] hh;
      logic [15:0] mm;
      logic [15:0] ss;
      logic [15:0] cc;
      logic [7:0]  b;
      hh = two_digits({2'b00, h});
      mm = two_digits({1'b0, m});
      ss = two_digits({1'b0, s});
      cc = two_digits(c);
      unique case (idx)
         4'd0:    b = hh[15:8];
         4'd1:    b = hh[7:0];
         4'd2:    b = 8'h3A;
         4'd3:    b = mm[15:8];
         4'd4:    b = mm[7:0];
         4'd5:    b = 8'h3A;
         4'd6:    b = ss[15:8];
         4'd7:    b = ss[7:0];
         4'd8:    b = 8'h2E;
         4'd9:    b = cc[15:8];
         4'd10:   b = cc[7:0];
         4'd11:   b = 8'h0D;
         4'd12:   b = 8'h0A;
         default: b = 8'h00;
      endcase
      return b;
   endfunction

   // Next-state logic: frame sequencing, pending-request tracking, snapshot load.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      pend_d  = pend_q;
      msec_d  = msec_q;
      sec_d   = sec_q;
      min_d   = min_q;
      hour_d  = hour_q;
      data_d  = data_q;
      load    = 1'b0;

      // Any request while a frame is in flight collapses into one pending flag.
      if (trig && (state_q != StIdle)) pend_d = 1'b1;

      unique case (state_q)
         StIdle: begin
            if (trig) load = 1'b1;
         end
         StSend: begin
            state_d = StWait;
         end
         StWait: begin
            if (i_tx_done) begin
               if (idx_q == LastIdx) begin
                  // A request on the final done edge restarts without an idle cycle.
                  if (pend_q || trig) load = 1'b1;
                  else                state_d = StIdle;
               end else begin
                  idx_d   = idx_q + 4'd1;
                  state_d = StSend;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      if (load) begin
         msec_d  = i_msec;
         sec_d   = i_sec;
         min_d   = i_min;
         hour_d  = i_hour;
         idx_d   = 4'd0;
         pend_d  = 1'b0;
         state_d = StSend;
      end

      // Register the byte on entry to SEND so it is stable through WAIT.
      if (state_d == StSend) data_d = frame_byte(hour_d, min_d, sec_d, msec_d, idx_d);
   end

   // State, snapshot and data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= 4'd0;
         pend_q  <= 1'b0;
         msec_q  <= 7'd0;
         sec_q   <= 6'd0;
         min_q   <= 6'd0;
         hour_q  <= 5'd0;
         data_q  <= 8'h00;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         msec_q  <= msec_d;
         sec_q   <= sec_d;
         min_q   <= min_d;
         hour_q  <= hour_d;
         data_q  <= data_d;
      end
   end

   assign o_tx_start = (state_q == StSend);
   assign o_busy     = (state_q != StIdle);
   assign o_tx_data  = data_q;

endmodule

// File: tb/tb_stopwatch_uart_reporter.sv
// Directed bench for stopwatch_uart_reporter with a simple UART TX responder.
// Build with REPORTER_PERIODIC_EN defined to exercise the periodic tick instead.
module tb_stopwatch_uart_reporter;

   logic       clk = 1'b0;
   logic       rst;
   logic       i_report;
   logic [6:0] i_msec;
   logic [5:0] i_sec;
   logic [5:0] i_min;
   logic [4:0] i_hour;
   logic       i_tx_done;
   logic       o_tx_start;
   logic [7:0] o_tx_data;
   logic       o_busy;

   int errors = 0;
   int checks = 0;

   logic [7:0] cap[$];
   int         busy_rise[$];
   int         cyc = 0;
   int         done_timer = 0;
   int         tx_delay = 10;
   bit         prev_busy = 1'b0;

   stopwatch_uart_reporter #(.REPORT_PERIOD(2000)) dut (
      .clk        (clk),
      .rst        (rst),
      .i_report   (i_report),
      .i_msec     (i_msec),
      .i_sec      (i_sec),
      .i_min      (i_min),
      .i_hour     (i_hour),
      .i_tx_done  (i_tx_done),
      .o_tx_start (o_tx_start),
      .o_tx_data  (o_tx_data),
      .o_busy     (o_busy)
   );

   always #5 clk = ~clk;

   // TX responder and capture: records each started byte, returns done tx_delay later.
   initial begin
      i_tx_done = 1'b0;
      forever begin
         @(negedge clk);
         cyc++;
         i_tx_done = 1'b0;
         if (rst === 1'b1) begin
            done_timer = 0;
         end else begin
            if (done_timer > 0) begin
               done_timer--;
               if (done_timer == 0) i_tx_done = 1'b1;
            end
            if (o_tx_start === 1'b1) begin
               cap.push_back(o_tx_data);
               done_timer = tx_delay;
            end
            if ((o_busy === 1'b1) && !prev_busy) busy_rise.push_back(cyc);
         end
         prev_busy = (o_busy === 1'b1);
      end
   end

   function automatic logic [7:0] cap_at(input int idx);
      if (idx < cap.size()) return cap[idx];
      return 8'hxx;
   endfunction

   // Index of first byte differing from exp starting at cap[base], or -1.
   function automatic int first_diff(input string exp, input int base);
      for (int i = 0; i < exp.len(); i++) begin
         if (base + i >= cap.size()) return i;
         if (cap[base + i] !== exp[i]) return i;
      end
      return -1;
   endfunction

   task automatic set_time(input int h, input int m, input int s, input int c);
      i_hour = 5'(h);
      i_min  = 6'(m);
      i_sec  = 6'(s);
      i_msec = 7'(c);
   endtask

   task automatic pulse_report();
      @(negedge clk);
      i_report = 1'b1;
      @(negedge clk);
      i_report = 1'b0;
   endtask

   // Waits (bounded) for n captured bytes; counts cycles with o_busy low meanwhile.
   task automatic wait_caps(input int n, input int bound, output int busy_low);
      busy_low = 0;
      for (int c = 0; c < bound; c++) begin
         if (cap.size() >= n) return;
         @(negedge clk);
         #1;
         if (o_busy !== 1'b1) busy_low++;
      end
   endtask

   task automatic wait_idle();
      for (int c = 0; c < 500; c++) begin
         if (o_busy === 1'b0) return;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      i_report = 1'b0;
      set_time(0, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (o_tx_start !== 1'b0) begin
         errors++;
         $display("FAIL reset_start: got %b want 0", o_tx_start);
      end
      checks++;
      if (o_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b want 0", o_busy);
      end
      checks++;
      if (o_tx_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data: got %h want 00", o_tx_data);
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_single();
      string exp = "12:34:56.78\r\n";
      int    bl;
      int    n;
      int    d;
      cap.delete();
      set_time(12, 34, 56, 78);
      pulse_report();
      #1;
      checks++;
      if (o_tx_start !== 1'b1) begin
         errors++;
         $display("FAIL latency_start: got %b want 1", o_tx_start);
      end
      checks++;
      if (o_busy !== 1'b1) begin
         errors++;
         $display("FAIL latency_busy: got %b want 1", o_busy);
      end
      checks++;
      if (o_tx_data !== 8'h31) begin
         errors++;
         $display("FAIL latency_data: got %h want 31", o_tx_data);
      end
      // Snapshot isolation: live inputs change after the first byte.
      set_time(1, 2, 3, 4);
      wait_caps(13, 400, bl);
      checks++;
      if (bl !== 0) begin
         errors++;
         $display("FAIL single_busy_held: got %0d low cycles want 0", bl);
      end
      n = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         #1;
         n++;
         if (o_busy === 1'b0) break;
      end
      checks++;
      if (n !== 11) begin
         errors++;
         $display("FAIL single_busy_fall: got %0d cycles want 11", n);
      end
      d = first_diff(exp, 0);
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL single_frame: byte %0d got %h want %h", d, cap_at(d), exp[d]);
      end
   endtask

   task automatic test_pending();
      string exp1 = "01:02:03.04\r\n";
      string exp2 = "05:06:07.08\r\n";
      int    bl;
      int    d;
      cap.delete();
      wait_idle();
      set_time(1, 2, 3, 4);
      pulse_report();
      wait_caps(3, 200, bl);
      repeat (3) begin
         pulse_report();
         repeat (4) @(negedge clk);
      end
      #1;
      wait_caps(10, 400, bl);
      set_time(5, 6, 7, 8);
      wait_caps(26, 800, bl);
      checks++;
      if (bl !== 0) begin
         errors++;
         $display("FAIL pending_back_to_back: got %0d busy-low cycles want 0", bl);
      end
      d = first_diff(exp1, 0);
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL pending_frame1: byte %0d got %h want %h", d, cap_at(d), exp1[d]);
      end
      d = first_diff(exp2, 13);
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL pending_frame2: byte %0d got %h want %h", d, cap_at(13 + d), exp2[d]);
      end
      repeat (300) @(negedge clk);
      #1;
      checks++;
      if (cap.size() !== 26 || o_busy !== 1'b0) begin
         errors++;
         $display("FAIL pending_collapse: got %0d bytes busy=%b want 26 bytes busy=0",
                  cap.size(), o_busy);
      end
   endtask

   task automatic test_back_to_back();
      string exp = "22:11:00.00\r\n";
      int    bl;
      int    d;
      cap.delete();
      wait_idle();
      set_time(22, 11, 0, 0);
      pulse_report();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         #1;
         if (i_tx_done === 1'b1 && cap.size() == 13) break;
      end
      // Request coincides with the final done edge.
      i_report = 1'b1;
      @(negedge clk);
      i_report = 1'b0;
      #1;
      bl = (o_busy !== 1'b1) ? 1 : 0;
      begin
         int bl2;
         wait_caps(26, 400, bl2);
         bl += bl2;
      end
      checks++;
      if (bl !== 0) begin
         errors++;
         $display("FAIL b2b_no_idle: got %0d busy-low cycles want 0", bl);
      end
      d = first_diff({exp, exp}, 0);
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL b2b_frames: byte %0d got %h want %h", d, cap_at(d), exp[d % 13]);
      end
      wait_idle();
   endtask

   task automatic test_saturation();
      string exp1 = "00:00:00.99\r\n";
      string exp2 = "31:59:59.99\r\n";
      int    bl;
      int    d;
      cap.delete();
      wait_idle();
      set_time(0, 0, 0, 120);
      pulse_report();
      wait_caps(13, 400, bl);
      wait_idle();
      d = first_diff(exp1, 0);
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL sat_zero: byte %0d got %h want %h", d, cap_at(d), exp1[d]);
      end
      cap.delete();
      set_time(31, 59, 59, 100);
      pulse_report();
      wait_caps(13, 400, bl);
      wait_idle();
      d = first_diff(exp2, 0);
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL sat_hour31: byte %0d got %h want %h", d, cap_at(d), exp2[d]);
      end
   endtask

   task automatic test_reset_mid();
      string exp = "09:08:07.06\r\n";
      int    bl;
      int    d;
      cap.delete();
      wait_idle();
      set_time(9, 8, 7, 6);
      pulse_report();
      wait_caps(3, 200, bl);
      pulse_report();
      #1;
      wait_caps(6, 200, bl);
      rst = 1'b1;
      #1;
      checks++;
      if (o_tx_start !== 1'b0 || o_busy !== 1'b0 || o_tx_data !== 8'h00) begin
         errors++;
         $display("FAIL reset_mid_outputs: got start=%b busy=%b data=%h want 0 0 00",
                  o_tx_start, o_busy, o_tx_data);
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (300) @(negedge clk);
      #1;
      checks++;
      if (cap.size() !== 6) begin
         errors++;
         $display("FAIL reset_mid_quiet: got %0d bytes want 6", cap.size());
      end
      cap.delete();
      pulse_report();
      wait_caps(13, 400, bl);
      wait_idle();
      d = first_diff(exp, 0);
      checks++;
      if (d != -1) begin
         errors++;
         $display("FAIL reset_mid_resume: byte %0d got %h want %h", d, cap_at(d), exp[d]);
      end
   endtask

`ifdef REPORTER_PERIODIC_EN
   task automatic test_periodic();
      int gap;
      tx_delay = 1;
      busy_rise.delete();
      repeat (4300) @(negedge clk);
      #1;
      checks++;
      if (busy_rise.size() < 2) begin
         errors++;
         $display("FAIL periodic_count: got %0d frames want >= 2", busy_rise.size());
      end else begin
         gap = busy_rise[1] - busy_rise[0];
         checks++;
         if (gap !== 2000) begin
            errors++;
            $display("FAIL periodic_gap: got %0d cycles want 2000", gap);
         end
      end
   endtask
`endif

   initial begin
      test_reset();
`ifdef REPORTER_PERIODIC_EN
      test_periodic();
`else
      test_single();
      test_pending();
      test_back_to_back();
      test_saturation();
      test_reset_mid();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
